// File: rtl/router_pkg.sv
// Shared encodings for the 1x3 router packet-sequencing controller.
package router_pkg;

  localparam int NUM_DEST = 3;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam logic [2:0] S_DA  = 3'd0;
  localparam logic [2:0] S_LFD = 3'd1;
  localparam logic [2:0] S_LD  = 3'd2;
  localparam logic [2:0] S_WTE = 3'd3;
  localparam logic [2:0] S_FFS = 3'd4;
  localparam logic [2:0] S_LAF = 3'd5;
  localparam logic [2:0] S_LP  = 3'd6;
  localparam logic [2:0] S_CPE = 3'd7;

  typedef enum logic [2:0] {
    ST_DA  = S_DA,
    ST_LFD = S_LFD,
    ST_LD  = S_LD,
    ST_WTE = S_WTE,
    ST_FFS = S_FFS,
    ST_LAF = S_LAF,
    ST_LP  = S_LP,
    ST_CPE = S_CPE
  } state_e;

  // Per-destination flag select; the invalid address selects nothing.
  function automatic logic pick_dest(
    input logic [NUM_DEST-1:0] v,
    input logic [1:0]          a
  );
    logic r;
    r = 1'b0;
    case (a)
      2'd0:    r = v[0];
      2'd1:    r = v[1];
      2'd2:    r = v[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing FSM of the 1x3 router: address decode,
// FIFO write strobes, full throttling and parity hand-off.
module router_fsm
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  logic [NUM_DEST-1:0] empty_v, srst_v;
  logic                hdr_ok;

  assign empty_v = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign srst_v  = {soft_reset_2, soft_reset_1, soft_reset_0};
  assign hdr_ok  = pkt_valid && (data_in != ADDR_INVALID);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == ST_DA && pkt_valid)
      addr_d = data_in;
    // A soft reset of the selected port aborts from any busy state.
    if (state_q != ST_DA && pick_dest(srst_v, addr_q)) begin
      state_d = ST_DA;
    end else begin
      case (state_q)
        ST_DA: begin
          if (hdr_ok)
            state_d = pick_dest(empty_v, data_in) ? ST_LFD : ST_WTE;
        end
        ST_LFD: state_d = ST_LD;
        ST_LD: begin
          if (fifo_full)       state_d = ST_FFS;
          else if (!pkt_valid) state_d = ST_LP;
        end
        ST_FFS: begin
          if (!fifo_full) state_d = ST_LAF;
        end
        ST_LAF: begin
          if (parity_done)        state_d = ST_DA;
          else if (low_pkt_valid) state_d = ST_LP;
          else                    state_d = ST_LD;
        end
        ST_LP:  state_d = ST_CPE;
        ST_CPE: state_d = fifo_full ? ST_FFS : ST_DA;
        ST_WTE: begin
          if (pick_dest(empty_v, addr_q)) state_d = ST_LFD;
        end
        default: state_d = ST_DA;
      endcase
    end
  end

  // Outputs are registered from the next state so they track state_q.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_DA;
      addr_q        <= 2'b00;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      full_state    <= 1'b0;
      laf_state     <= 1'b0;
      write_enb_reg <= 1'b0;
      rst_int_reg   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      detect_add    <= (state_d == ST_DA);
      lfd_state     <= (state_d == ST_LFD);
      ld_state      <= (state_d == ST_LD);
      full_state    <= (state_d == ST_FFS);
      laf_state     <= (state_d == ST_LAF);
      write_enb_reg <= (state_d == ST_LD) || (state_d == ST_LP) ||
                       (state_d == ST_LAF);
      rst_int_reg   <= (state_d == ST_CPE);
      busy          <= (state_d != ST_DA) && (state_d != ST_LD);
    end
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed vector bench for router_fsm: table of per-edge
// stimulus with expected Moore outputs, plus reset/invalid runs.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, full_state;
  logic       laf_state, write_enb_reg, rst_int_reg, busy;

  router_fsm dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .full_state    (full_state),
    .laf_state     (laf_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // {detect,lfd,ld,full,laf,wenb,rst_int,busy}
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0100;
  localparam logic [7:0] O_FFS = 8'b0001_0001;
  localparam logic [7:0] O_LAF = 8'b0000_1101;
  localparam logic [7:0] O_LP  = 8'b0000_0101;
  localparam logic [7:0] O_CPE = 8'b0000_0011;
  localparam logic [7:0] O_WTE = 8'b0000_0001;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] empty;
    logic [2:0] srst;
    logic       pd;
    logic       lpv;
    logic [7:0] want;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  wire [7:0] outs = {detect_add, lfd_state, ld_state, full_state,
                     laf_state, write_enb_reg, rst_int_reg, busy};

  function automatic vec_t mk(
    input logic pv, input logic [1:0] din, input logic full,
    input logic [2:0] empty, input logic [2:0] srst,
    input logic pd, input logic lpv, input logic [7:0] want);
    vec_t v;
    v.pv = pv; v.din = din; v.full = full; v.empty = empty;
    v.srst = srst; v.pd = pd; v.lpv = lpv; v.want = want;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    pkt_valid     = v.pv;
    data_in       = v.din;
    fifo_full     = v.full;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = v.empty;
    {soft_reset_2, soft_reset_1, soft_reset_0} = v.srst;
    parity_done   = v.pd;
    low_pkt_valid = v.lpv;
  endtask

  task automatic check(input string tag, input int idx,
                       input logic [7:0] want);
    checks++;
    if (outs !== want) begin
      errors++;
      $display("FAIL %s[%0d]: outputs got %b want %b",
               tag, idx, outs, want);
    end
  endtask

  task automatic apply(input vec_t v, input string tag, input int idx);
    drive(v);
    @(posedge clock);
    #1;
    check(tag, idx, v.want);
  endtask

  initial begin
    vec_t idle;
    int   bad_seen;
    idle = mk(0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_DA);

    // Normal packet to port 1
    vecs.push_back(mk(1, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_LFD));
    vecs.push_back(mk(1, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_LD));
    vecs.push_back(mk(1, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_LD));
    vecs.push_back(mk(1, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_LD));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_LP));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_CPE));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_DA));
    // Busy destination 2: WTE for 4 cycles
    vecs.push_back(mk(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, O_WTE));
    vecs.push_back(mk(1, 2'd0, 0, 3'b011, 3'b000, 0, 0, O_WTE));
    vecs.push_back(mk(1, 2'd0, 0, 3'b011, 3'b000, 0, 0, O_WTE));
    vecs.push_back(mk(1, 2'd0, 0, 3'b011, 3'b000, 0, 0, O_WTE));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LFD));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD));
    // Full stall, release, low_pkt_valid -> LP
    vecs.push_back(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FFS));
    vecs.push_back(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FFS));
    vecs.push_back(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FFS));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, O_LP));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_CPE));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DA));
    // Full stall, parity_done beats low_pkt_valid
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LFD));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD));
    vecs.push_back(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FFS));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 1, 1, O_DA));
    // full beats pkt_valid low; LAF->LD; LP->CPE; CPE full->FFS
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LFD));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD));
    vecs.push_back(mk(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FFS));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LP));
    vecs.push_back(mk(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_CPE));
    vecs.push_back(mk(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FFS));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 1, 0, O_DA));
    // Soft reset in FFS, addr 0: port 1 ignored, port 0 beats full
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LFD));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD));
    vecs.push_back(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FFS));
    vecs.push_back(mk(1, 2'd0, 1, 3'b111, 3'b010, 0, 0, O_FFS));
    vecs.push_back(mk(1, 2'd0, 1, 3'b111, 3'b001, 0, 0, O_DA));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DA));
    // Soft reset in WTE, addr 2
    vecs.push_back(mk(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, O_WTE));
    vecs.push_back(mk(0, 2'd0, 0, 3'b011, 3'b001, 0, 0, O_WTE));
    vecs.push_back(mk(0, 2'd0, 0, 3'b011, 3'b100, 0, 0, O_DA));
    // pkt_valid low in DA holds even with an empty target
    vecs.push_back(mk(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_DA));

    drive(idle);
    resetn = 1'b0;
    #12;
    check("reset", 0, O_DA);
    @(negedge clock);
    resetn = 1'b1;

    foreach (vecs[i]) apply(vecs[i], "vec", i);

    // Reset asserted mid-LD aborts at once
    apply(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LFD), "rst_seq", 0);
    apply(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD), "rst_seq", 1);
    #3;
    resetn = 1'b0;
    #1;
    check("rst_mid_ld", 0, O_DA);
    @(negedge clock);
    resetn = 1'b1;
    apply(idle, "rst_seq", 2);

    // Invalid address for 10 cycles: never leaves DA
    bad_seen = 0;
    for (int k = 0; k < 10; k++) begin
      apply(mk(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, O_DA), "invalid", k);
      if (lfd_state || write_enb_reg) bad_seen++;
    end
    checks++;
    if (bad_seen != 0) begin
      errors++;
      $display("FAIL invalid_strobe: got %0d strobe cycles want 0",
               bad_seen);
    end
    apply(idle, "invalid", 10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
